// File: rtl/lbus_master_pkg.sv
// Shared types and constants for the byte-stream local-bus initiator.
package lbus_pkg;

  localparam int LBUS_ADDR_W = 24;
  localparam int LBUS_DATA_W = 8;

  // Command byte layout: read/write flag on top, burst length minus one below it.
  localparam int CMD_RW_BIT  = 7;
  localparam int CMD_LEN_MSB = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_WR_STROBE,
    ST_RD_STROBE,
    ST_RD_SEND,
    ST_GAP
  } lbus_master_state_t;

endpackage

// File: rtl/lbus_master_if.sv
// Byte source, byte sink and local register bus signals of the initiator.
interface lbus_master_if;
  import lbus_pkg::*;

  logic                   rx_valid;
  logic [7:0]             rx_data;
  logic                   rx_ready;
  logic                   tx_valid;
  logic [7:0]             tx_data;
  logic                   tx_ready;
  logic                   lbus_wr_en;
  logic                   lbus_rd_en;
  logic [LBUS_ADDR_W-1:0] lbus_address;
  logic [LBUS_DATA_W-1:0] lbus_wdata;
  logic [LBUS_DATA_W-1:0] lbus_rdata;

  modport master (
    input  rx_valid, rx_data, tx_ready, lbus_rdata,
    output rx_ready, tx_valid, tx_data,
    output lbus_wr_en, lbus_rd_en, lbus_address, lbus_wdata
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, lbus_rdata,
    input  rx_ready, tx_valid, tx_data,
    input  lbus_wr_en, lbus_rd_en, lbus_address, lbus_wdata
  );

endinterface

// File: rtl/lbus_master_strobe_timer.sv
// Down-counter shared by the strobe and gap states; flags the final cycle of a phase.
module lbus_strobe_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             last
);

  logic [WIDTH-1:0] cnt;

  // Load with (phase length - 1) on entry, then count down and park at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (cnt != '0) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/lbus_master.sv
// Command-byte parser driving stretched, gapped rd/wr strobes on the local bus.
// Optional inter-byte timeout is compiled in with LBUS_MASTER_TIMEOUT_EN.
module lbus_master
  import lbus_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int unsigned GAP_CYCLES     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  lbus_master_if.master bus,
  output logic          busy
);

  lbus_master_state_t state, next_state;

  logic        rw;
  logic [7:0]  count;
  logic [1:0]  byte_idx;
  logic        ready_en;
  logic        rx_fire;
  logic        tx_fire;
  logic        timer_load;
  logic [31:0] timer_value;
  logic        timer_last;
  logic        timeout_hit;

  // rx_ready stays low through reset and rises one cycle after release.
  assign bus.rx_ready = ready_en &&
                        (state == ST_IDLE || state == ST_ADDR || state == ST_WDATA);
  assign rx_fire        = bus.rx_valid && bus.rx_ready;
  assign tx_fire        = bus.tx_valid && bus.tx_ready;
  assign bus.tx_valid   = (state == ST_RD_SEND);
  assign bus.lbus_wr_en = (state == ST_WR_STROBE);
  assign bus.lbus_rd_en = (state == ST_RD_STROBE);
  assign busy           = (state != ST_IDLE);

  lbus_strobe_timer #(.WIDTH(32)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_value),
    .last       (timer_last)
  );

`ifdef LBUS_MASTER_TIMEOUT_EN
  logic [31:0] idle_cnt;

  // Count silent cycles while a frame is waiting for bytes; any accepted byte restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if ((state != ST_ADDR && state != ST_WDATA) || rx_fire) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end

  assign timeout_hit = (idle_cnt == 32'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  // Holds ready low until the first edge after reset is released.
  always_ff @(posedge clk) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state decode; the timer is loaded on every entry into a strobe or gap phase.
  always_comb begin
    next_state  = state;
    timer_load  = 1'b0;
    timer_value = 32'(HOLD_CYCLES - 1);
    case (state)
      ST_IDLE: begin
        if (rx_fire) next_state = ST_ADDR;
      end
      ST_ADDR: begin
        if (rx_fire) begin
          if (byte_idx == 2'd2) begin
            if (rw) begin
              next_state = ST_RD_STROBE;
              timer_load = 1'b1;
            end else begin
              next_state = ST_WDATA;
            end
          end
        end else if (timeout_hit) begin
          next_state = ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (rx_fire) begin
          next_state = ST_WR_STROBE;
          timer_load = 1'b1;
        end else if (timeout_hit) begin
          next_state = ST_IDLE;
        end
      end
      ST_WR_STROBE, ST_RD_STROBE: begin
        if (timer_last) begin
          next_state  = (state == ST_RD_STROBE) ? ST_RD_SEND : ST_GAP;
          timer_load  = (state == ST_WR_STROBE);
          timer_value = 32'(GAP_CYCLES - 1);
        end
      end
      ST_RD_SEND: begin
        if (tx_fire) begin
          next_state  = ST_GAP;
          timer_load  = 1'b1;
          timer_value = 32'(GAP_CYCLES - 1);
        end
      end
      ST_GAP: begin
        if (timer_last) begin
          if (count == 8'd1) begin
            next_state = ST_IDLE;
          end else if (rw) begin
            next_state = ST_RD_STROBE;
            timer_load = 1'b1;
          end else begin
            next_state = ST_WDATA;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Frame datapath: command fields, address shift/increment, write data and read capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rw               <= 1'b0;
      count            <= '0;
      byte_idx         <= '0;
      bus.lbus_address <= '0;
      bus.lbus_wdata   <= '0;
      bus.tx_data      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_fire) begin
            rw       <= bus.rx_data[CMD_RW_BIT];
            count    <= {1'b0, bus.rx_data[CMD_LEN_MSB:0]} + 8'd1;
            byte_idx <= '0;
          end
        end
        ST_ADDR: begin
          if (rx_fire) begin
            bus.lbus_address <= {bus.lbus_address[LBUS_ADDR_W-LBUS_DATA_W-1:0], bus.rx_data};
            byte_idx         <= byte_idx + 2'd1;
          end
        end
        ST_WDATA: begin
          if (rx_fire) bus.lbus_wdata <= bus.rx_data;
        end
        ST_RD_STROBE: begin
          if (timer_last) bus.tx_data <= bus.lbus_rdata;
        end
        ST_GAP: begin
          if (timer_last) begin
            count <= count - 8'd1;
            if (count != 8'd1) bus.lbus_address <= bus.lbus_address + LBUS_ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lbus_master.sv
// Self-checking bench for lbus_master: directed frames plus random frames against a
// memory-level reference model. Timeout expectations follow LBUS_MASTER_TIMEOUT_EN.
module tb_lbus_master;

  localparam int HOLD = 4;

  typedef struct {
    bit          is_write;
    logic [23:0] addr;
    logic [7:0]  data;
    int          len;
  } acc_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  always #5 clk = ~clk;

  lbus_master_if bus();

  lbus_master #(
    .HOLD_CYCLES    (4),
    .GAP_CYCLES     (3),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  int checks = 0;
  int errors = 0;

  int unsigned cyc = 0;
  int unsigned last_hs = 0;
  int unsigned last_rise_cyc = 0;
  int unsigned last_fall_cyc = 0;
  int unsigned idle_cyc = 0;
  int strobe_count = 0;
  int rd_count = 0;
  int gap_len = 1000;
  bit in_strobe = 1'b0;
  acc_t cur;

  acc_t obs_q[$];
  acc_t exp_q[$];
  logic [7:0] data_q[$];

  logic [7:0] reg_mem [logic [23:0]];
  logic [7:0] model_mem [logic [23:0]];
  logic prev_wr = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] reg_read(input logic [23:0] a);
    return reg_mem.exists(a) ? reg_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] model_read(input logic [23:0] a);
    return model_mem.exists(a) ? model_mem[a] : 8'h00;
  endfunction

  function automatic logic [63:0] pack_outputs();
    return {19'd0, bus.rx_ready, bus.tx_valid, bus.tx_data, bus.lbus_wr_en,
            bus.lbus_rd_en, bus.lbus_address, bus.lbus_wdata, busy};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Register map model: edge-detects the write strobe, returns registered read data.
  always @(posedge clk) begin
    prev_wr <= bus.lbus_wr_en;
    if (bus.lbus_wr_en && !prev_wr) reg_mem[bus.lbus_address] = bus.lbus_wdata;
    bus.lbus_rdata <= reg_read(bus.lbus_address);
  end

  // Strobe monitor: records each access and checks exclusivity, hold-off and stability.
  always @(negedge clk) begin
    if (bus.lbus_wr_en || bus.lbus_rd_en) begin
      checkOutput("strobe_excl", {63'd0, bus.lbus_wr_en & bus.lbus_rd_en}, 64'd0);
      checkOutput("rx_held_off", {63'd0, bus.rx_ready}, 64'd0);
      if (!in_strobe) begin
        in_strobe     = 1'b1;
        cur.is_write  = bus.lbus_wr_en;
        cur.addr      = bus.lbus_address;
        cur.data      = bus.lbus_wdata;
        cur.len       = 1;
        last_rise_cyc = cyc;
        strobe_count++;
        if (bus.lbus_rd_en) rd_count++;
        checkOutput("gap_len_ok", {63'd0, gap_len >= 3}, 64'd1);
      end else begin
        cur.len++;
        checkOutput("addr_stable", bus.lbus_address, cur.addr);
        checkOutput("wdata_stable", bus.lbus_wdata, cur.data);
      end
    end else begin
      if (in_strobe) begin
        in_strobe = 1'b0;
        if (!cur.is_write) cur.data = 8'h00;
        obs_q.push_back(cur);
        last_fall_cyc = cyc;
        gap_len = 0;
      end
      if (gap_len < 1000) gap_len++;
      if (gap_len <= 3 && busy) begin
        checkOutput("gap_addr_stable", bus.lbus_address, cur.addr);
        if (cur.is_write) checkOutput("gap_wdata_stable", bus.lbus_wdata, cur.data);
      end
    end
  end

  task automatic sendByte(input logic [7:0] b);
    int budget = 0;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("rx_ready_within_budget", {63'd0, bus.rx_ready}, 64'd1);
    last_hs = cyc;
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic recvByte(input logic [7:0] exp, input int stall);
    int budget = 0;
    int rd_before;
    @(negedge clk);
    while (!bus.tx_valid && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("tx_valid_within_budget", {63'd0, bus.tx_valid}, 64'd1);
    rd_before = rd_count;
    repeat (stall) @(negedge clk);
    if (stall > 0) begin
      checkOutput("no_rd_during_stall", rd_count, rd_before);
      checkOutput("tx_valid_held", {63'd0, bus.tx_valid}, 64'd1);
    end
    checkOutput("tx_data", bus.tx_data, exp);
    bus.tx_ready = 1'b1;
    @(posedge clk);
    #1 bus.tx_ready = 1'b0;
  endtask

  task automatic waitIdle();
    int budget = 0;
    @(negedge clk);
    while (busy && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("idle_within_budget", {63'd0, busy}, 64'd0);
    idle_cyc = cyc;
  endtask

  task automatic compareAccesses();
    acc_t o, e;
    checkOutput("access_count", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checkOutput("acc_kind", {63'd0, o.is_write}, {63'd0, e.is_write});
      checkOutput("acc_addr", o.addr, e.addr);
      if (e.is_write) checkOutput("acc_wdata", o.data, e.data);
      checkOutput("strobe_len", o.len, e.len);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // One full frame: model predicts accesses/read bytes, then the frame is driven and checked.
  task automatic applyStimulus(input bit is_read, input int n, input logic [23:0] addr,
                               input int stall_second);
    logic [7:0]  exp_tx[$];
    logic [23:0] a;
    for (int i = 0; i < n; i++) begin
      a = addr + 24'(i);
      if (is_read) begin
        exp_q.push_back('{1'b0, a, 8'h00, HOLD});
        exp_tx.push_back(model_read(a));
      end else begin
        exp_q.push_back('{1'b1, a, data_q[i], HOLD});
        model_mem[a] = data_q[i];
      end
    end
    sendByte({is_read, 7'(n - 1)});
    sendByte(addr[23:16]);
    sendByte(addr[15:8]);
    sendByte(addr[7:0]);
    for (int i = 0; i < n; i++) begin
      if (is_read) recvByte(exp_tx[i], (i == 1) ? stall_second : int'($urandom_range(0, 2)));
      else         sendByte(data_q[i]);
    end
    waitIdle();
    compareAccesses();
    data_q.delete();
  endtask

  initial begin
    int sc;
    bit          r_read;
    int          r_n;
    logic [23:0] r_addr;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", pack_outputs(), 64'd0);
    rst_n = 1'b1;
    #1 checkOutput("rx_ready_release_cycle", {63'd0, bus.rx_ready}, 64'd0);
    @(negedge clk);
    checkOutput("rx_ready_after_release", {63'd0, bus.rx_ready}, 64'd1);

    $display("[TB] single write");
    data_q = '{8'hAB};
    applyStimulus(1'b0, 1, 24'h000002, 0);
    checkOutput("strobe_rise_latency", last_rise_cyc - last_hs, 1);
    checkOutput("busy_fall_after_strobe", idle_cyc - last_fall_cyc, 3);

    $display("[TB] three-byte write");
    data_q = '{8'h11, 8'h22, 8'h33};
    applyStimulus(1'b0, 3, 24'h000002, 0);
    checkOutput("end_address", {40'd0, reg_read(24'd2), reg_read(24'd3), reg_read(24'd4)},
                64'h112233);

    $display("[TB] read with stalled sink");
    data_q = '{8'h03, 8'h5A};
    applyStimulus(1'b0, 2, 24'h000000, 0);
    applyStimulus(1'b1, 2, 24'h000000, 50);

    $display("[TB] address wrap");
    data_q = '{8'h01, 8'h02};
    applyStimulus(1'b0, 2, 24'hFFFFFF, 0);

    $display("[TB] reset mid-strobe");
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h10);
    sendByte(8'h77);
    sc = 0;
    @(negedge clk);
    while (!bus.lbus_wr_en && sc < 50) begin
      @(negedge clk);
      sc++;
    end
    checkOutput("wr_strobe_seen", {63'd0, bus.lbus_wr_en}, 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    model_mem[24'h000010] = 8'h77;
    @(posedge clk);
    #1 checkOutput("reset_mid_strobe", pack_outputs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    data_q = '{8'h5C};
    applyStimulus(1'b0, 1, 24'h000010, 0);
    applyStimulus(1'b1, 1, 24'h000010, 0);

    $display("[TB] random frames");
    for (int f = 0; f < 14; f++) begin
      r_read = 1'($urandom_range(0, 1));
      r_n    = int'($urandom_range(1, 6));
      r_addr = ($urandom_range(0, 3) == 0) ? 24'hFFFFFD + 24'($urandom_range(0, 2))
                                           : 24'($urandom_range(0, 15));
      if (!r_read) for (int i = 0; i < r_n; i++) data_q.push_back(8'($urandom));
      applyStimulus(r_read, r_n, r_addr, int'($urandom_range(0, 4)));
    end

    $display("[TB] 128-byte bursts");
    for (int i = 0; i < 128; i++) data_q.push_back(8'($urandom));
    applyStimulus(1'b0, 128, 24'h000100, 0);
    applyStimulus(1'b1, 128, 24'h000100, 3);

    $display("[TB] partial frame");
    sendByte(8'h00);
    sendByte(8'h12);
    sc = strobe_count;
    repeat (150) @(negedge clk);
    checkOutput("no_strobe_on_partial", strobe_count, sc);
`ifdef LBUS_MASTER_TIMEOUT_EN
    checkOutput("timeout_to_idle", {63'd0, busy}, 64'd0);
`else
    checkOutput("waits_in_addr", {62'd0, busy, bus.rx_ready}, 64'd3);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
